// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory between the instruction-fetch
// requester and the load/store requester. Data accesses win by default. A
// saturating streak counter limits how many data grants can go by in a row
// while a fetch is waiting. Read data returns one cycle after its grant and is
// tagged back to its owner by registered valid flags.
// MAX_DSTREAK must lie in 1..15 so that it fits the 4-bit streak counter.

module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic            clk,
  input  logic            rst,

  // Instruction-fetch requester (read only)
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,

  // Load/store requester
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,

  // Memory macro port
  input  logic            mem_ready,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int         BW         = DW / 8;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  // Consecutive data grants issued while a fetch was waiting
  logic [3:0] streak_q, streak_d;

  // Owner flags for the response arriving on mem_rdata next cycle
  logic       i_rvalid_q, i_rvalid_d;
  logic       d_rvalid_q, d_rvalid_d;

  // Arbitration terms
  logic       grant_ok;
  logic       fetch_turn;
  logic       i_gnt_w;
  logic       d_gnt_w;

  // Arbitration: at most one grant, only while memory is ready and out of reset
  always_comb begin
    // NOTE: every signal driven from always_comb gets a value on every path
    // (here directly, elsewhere via a default at the top) so no latch is inferred.
    grant_ok   = mem_ready & rst;
    fetch_turn = i_req & (streak_q == STREAK_MAX);
    i_gnt_w    = grant_ok & i_req & (fetch_turn | ~d_req);
    d_gnt_w    = grant_ok & d_req & ~fetch_turn;
  end

  // Memory command mux: fetch command, data command, or all zero when idle
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (i_gnt_w) begin
      mem_en    = 1'b1;
      mem_we    = 1'b0;
      mem_addr  = i_addr;
      mem_wdata = '0;
      mem_be    = {BW{1'b1}};
    end else if (d_gnt_w) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end
  end

  // Next-state for the streak counter and the response owner flags
  always_comb begin
    streak_d = streak_q;
    if (!i_req || i_gnt_w) begin
      // No fetch waiting, or the fetch just got its turn: start over
      streak_d = '0;
    end else if (d_gnt_w && (streak_q < STREAK_MAX)) begin
      streak_d = streak_q + 4'd1;
    end
    // Writes complete at grant and produce no response
    i_rvalid_d = i_gnt_w;
    d_rvalid_d = d_gnt_w & ~d_we;
  end

  // State registers; async reset also drops any response still in flight
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      streak_q   <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      streak_q   <= streak_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
    end
  end

  // Grants are combinational; response data is the memory data passed through
  assign i_gnt    = i_gnt_w;
  assign d_gnt    = d_gnt_w;
  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// traffic, all checked against a cycle-level reference model of the grant rules,
// the starvation guard and the response routing.

module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_be = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_ready = 1'b1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DSTREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ready(mem_ready), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // Initial memory image shared by the environment memory and the reference
  function automatic logic [DW-1:0] seed_word(input int k);
    if (k == 64) return 32'hDEAD_BEEF;
    return (32'(k) * 32'h9E37_79B1) + 32'h0123_4567;
  endfunction

  // Environment: synchronous memory macro driven by the DUT command
  logic [DW-1:0] env_mem [256];
  bit            env_wr  [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        logic [DW-1:0] w;
        w = env_wr[mem_addr[9:2]] ? env_mem[mem_addr[9:2]] : seed_word(int'(mem_addr[9:2]));
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        env_mem[mem_addr[9:2]] <= w;
        env_wr[mem_addr[9:2]]  <= 1'b1;
      end else begin
        mem_rdata <= env_wr[mem_addr[9:2]] ? env_mem[mem_addr[9:2]]
                                           : seed_word(int'(mem_addr[9:2]));
      end
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  int            m_streak;
  bit            m_i_rv, m_d_rv;
  logic [DW-1:0] m_i_data, m_d_data;
  bit            got_i, got_d;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample and check at the falling edge, advance the model,
  // then return just after the rising edge so the caller can drive new inputs.
  task automatic step();
    bit ok, ei, ed;
    logic [79:0] exp_cmd;
    @(negedge clk);
    #1;
    ok = mem_ready && rst;
    ei = ok && i_req && (!d_req || (m_streak == MAXS));
    ed = ok && d_req && !ei;
    got_i = i_gnt;
    got_d = d_gnt;
    check("i_gnt", 80'(i_gnt), 80'(ei));
    check("d_gnt", 80'(d_gnt), 80'(ed));
    check("mem_en", 80'(mem_en), 80'(ei || ed));
    if (ei)      exp_cmd = 80'({1'b0, i_addr, 32'h0, 4'hF});
    else if (ed) exp_cmd = 80'({d_we, d_addr, d_wdata, d_be});
    else         exp_cmd = '0;
    check("mem_cmd", 80'({mem_we, mem_addr, mem_wdata, mem_be}), exp_cmd);
    check("i_rvalid", 80'(i_rvalid), 80'(m_i_rv));
    check("d_rvalid", 80'(d_rvalid), 80'(m_d_rv));
    if (m_i_rv) check("i_rdata", 80'(i_rdata), 80'(m_i_data));
    if (m_d_rv) check("d_rdata", 80'(d_rdata), 80'(m_d_data));

    if (!rst) begin
      m_streak = 0;
      m_i_rv   = 1'b0;
      m_d_rv   = 1'b0;
    end else begin
      m_i_rv = ei;
      if (ei) m_i_data = ref_mem[i_addr[9:2]];
      m_d_rv = ed && !d_we;
      if (ed && !d_we) m_d_data = ref_mem[d_addr[9:2]];
      if (ed && d_we)
        for (int b = 0; b < BW; b++)
          if (d_be[b]) ref_mem[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
      if (!i_req || ei)               m_streak = 0;
      else if (ed && m_streak < MAXS) m_streak = m_streak + 1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [7:0] w;
    w = 8'($urandom);
    return {22'h0, w, 2'b00};
  endfunction

  logic [9:0] seq10;
  logic [2:0] seq3;
  int         bp_grants;

  initial begin
    for (int k = 0; k < 256; k++) begin
      ref_mem[k] = seed_word(k);
      env_wr[k]  = 1'b0;
    end
    m_streak = 0;
    m_i_rv   = 1'b0;
    m_d_rv   = 1'b0;
    m_i_data = '0;
    m_d_data = '0;

    // Reset held with both requesters asking
    rst = 1'b0; i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; mem_ready = 1'b1;
    #1;
    check("rst_i_gnt", 80'(i_gnt), 80'd0);
    check("rst_mem_en", 80'(mem_en), 80'd0);
    step(); step();
    rst = 1'b1;
    step();
    check("post_rst_d_gnt", 80'(got_d), 80'd1);
    check("post_rst_i_gnt", 80'(got_i), 80'd0);

    // Fetch only
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h100;
    step();
    check("fetch_i_gnt", 80'(got_i), 80'd1);
    i_req = 1'b0;
    check("fetch_i_rvalid", 80'(i_rvalid), 80'd1);
    check("fetch_i_rdata", 80'(i_rdata), 80'(32'hDEAD_BEEF));
    check("fetch_d_rvalid", 80'(d_rvalid), 80'd0);
    step();

    // Store
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'h1234_5678; d_addr = 32'h40;
    step();
    check("store_d_gnt", 80'(got_d), 80'd1);
    check("store_no_rvalid", 80'(d_rvalid), 80'd0);
    d_req = 1'b0; d_we = 1'b0;
    step();

    // Priority and fairness
    i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    for (int k = 0; k < 10; k++) begin
      step();
      seq10[k] = got_i;
    end
    check("fair_seq", 80'(seq10), 80'(10'b10_0001_0000));

    // Backpressure: two data grants, three stalled cycles, then resume
    step(); step();
    mem_ready = 1'b0;
    bp_grants = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      bp_grants += int'(got_i) + int'(got_d);
    end
    check("bp_no_grants", 80'(bp_grants), 80'd0);
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      seq3[k] = got_i;
    end
    check("bp_resume_seq", 80'(seq3), 80'(3'b100));

    // Reset mid-read
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h100;
    step();
    check("midrst_i_gnt", 80'(got_i), 80'd1);
    rst = 1'b0;
    m_streak = 0; m_i_rv = 1'b0; m_d_rv = 1'b0;
    #1;
    check("midrst_i_rvalid", 80'(i_rvalid), 80'd0);
    i_req = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    check("midrst_after_rvalid", 80'(i_rvalid), 80'd0);

    // Randomized traffic; each requester holds its command until granted
    for (int n = 0; n < 400; n++) begin
      if (!i_req || got_i) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = rand_addr();
      end
      if (!d_req || got_d) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = rand_addr();
        d_wdata = $urandom;
        d_be    = 4'($urandom);
      end
      mem_ready = ($urandom_range(0, 4) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
